stage_mem: RTL
==============

// Module: stage_mem
// PURPOSE
//  Memory-access stage, directly downstream of the ALU stage. Registers ALU results and decoded flags.
//  Runs load/store transactions on a req/gnt/rvalid data-memory port, sign/zero-extends load data,
//  resolves branch/jump redirects, and feeds writeback. Stalls upstream while a transaction is open.
// PARAMETERS
//  WD_SIZE         32  data word width (PARAMS_pkg)
//  INSTR_SIZE      32  PC / address width (PARAMS_pkg)
//  INSTR_REG_BITS  5   register index width (PARAMS_pkg)
// PORTS
//  clk            in   1               single clock, rising edge
//  reset_n        in   1               asynchronous, active-low reset
//  valid_i        in   1               ALU-stage outputs hold a live instruction
//  rd_i           in   INSTR_REG_BITS  destination register
//  instr_op_i/instr_ld_i/instr_st_i/instr_jm_i/instr_br_i  in  1 each  one-hot class flags
//  funct3_i       in   3               access size / branch sense
//  alu_result_i   in   WD_SIZE         arith result or effective address
//  alu_zero_i     in   1               ALU zero flag
//  rs2_data_i     in   WD_SIZE         store data
//  pc_target_i    in   INSTR_SIZE      branch/jump target
//  stall_o        out  1               upstream must hold inputs
//  dmem_req_o     out  1               memory request
//  dmem_we_o      out  1               1 = store
//  dmem_addr_o    out  INSTR_SIZE      word-aligned address ({addr[31:2],2'b00})
//  dmem_be_o      out  4               byte enables
//  dmem_wdata_o   out  WD_SIZE         lane-shifted store data
//  dmem_gnt_i     in   1               request accepted
//  dmem_rvalid_i  in   1               read data valid
//  dmem_rdata_i   in   WD_SIZE         read data
//  valid_o        out  1               writeback-side outputs valid (1-cycle pulse per instr)
//  rd_o           out  INSTR_REG_BITS  destination register
//  wb_en_o        out  1               write rd (op or load, rd!=0)
//  wb_data_o      out  WD_SIZE         writeback value
//  redirect_o     out  1               taken branch or jump (with valid_o)
//  pc_target_o    out  INSTR_SIZE      redirect target
//  misalign_o     out  1               misaligned access exception (with valid_o)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE; reset mid-transaction abandons it, no valid_o emitted.
//  FSM IDLE: valid_i & op/jm/br -> register results, valid_o next cycle, stall_o=0.
//  IDLE: valid_i & ld/st aligned -> dmem_req_o=1 combinationally; gnt same cycle -> (st: done; ld: WAIT)
//    else -> REQ. stall_o=1 from that cycle until completion cycle inclusive.
//  REQ: hold req/addr/be/wdata stable until dmem_gnt_i; then st->IDLE (valid_o next), ld->WAIT.
//  WAIT: req=0; on dmem_rvalid_i capture extended data, ->IDLE, valid_o next cycle.
//  rvalid on the gnt cycle is never expected; rvalid in IDLE/REQ is ignored.
//  Misaligned (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0): no request, valid_o+misalign_o next cycle,
//    wb_en_o=0.
//  Size via funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other values treated as W.
//  Loads: select lane by addr[1:0], sign-extend (B,H) or zero-extend (BU,HU).
//  Stores: be = 0001<<a (B), 0011<<a (H), 1111 (W); wdata = data replicated to all lanes.
//  Branch taken = instr_br_i & (alu_zero_i ^ funct3_i[0]); jump always redirects,
//    wb_data_o = pc_target_i for jumps is NOT used (jm writes rd=alu_result_i).
//  wb_en_o = valid_o & (op|ld|jm) & (rd_o!=0) & !misalign_o. Stores/branches never write.
//  Latency: non-mem 1 cycle; store 1+gnt wait; load 1+gnt wait+rvalid wait.
// STRUCTURE
//  PARAMS_pkg: mem_state_t enum {IDLE,REQ,WAIT}, FUNCT3_LB..LHU, FUNCT3 branch constants.
//  Sub-module lsu_align: combinational store-lane/byte-enable generation and load extension.
// TESTING
//  ADD: alu_result_i=0x1234, rd_i=5 -> next cycle valid_o=1, wb_en_o=1, wb_data_o=0x1234, no req.
//  LB addr 0x103, rdata 0x80FFFFFF, gnt same cycle, rvalid +2 -> wb_data_o=0xFFFFFF80, stall 3 cycles.
//  SH addr 0x102 data 0xBEEF, gnt delayed 3 cycles -> be=1100, wdata=0xBEEFBEEF held stable, wb_en_o=0.
//  LW addr 0x101 -> no dmem_req_o, valid_o=1, misalign_o=1, wb_en_o=0.
//  BNE (funct3=001) alu_zero_i=0 -> redirect_o=1, pc_target_o=pc_target_i; BEQ zero=0 -> redirect_o=0.
//  reset_n low while in WAIT -> outputs 0 immediately, late rvalid ignored, next ADD completes normally.

Source files
------------

// File: rtl/PARAMS_pkg.sv
// Shared widths, memory-stage FSM states and funct3 encodings for the memory stage.
package PARAMS_pkg;

  localparam int WD_SIZE        = 32;
  localparam int INSTR_SIZE     = 32;
  localparam int INSTR_REG_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Branch sense lives in funct3[0]: BNE style compares take on a non-zero result.
  localparam logic [2:0] FUNCT3_BNE = 3'b001;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic acc_size_t decode_size(input logic [2:0] f3);
    acc_size_t sz;
    case (f3)
      FUNCT3_LB, FUNCT3_LBU: sz = SZ_B;
      FUNCT3_LH, FUNCT3_LHU: sz = SZ_H;
      FUNCT3_LW:             sz = SZ_W;
      default:               sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic branch_taken(input logic zero, input logic [2:0] f3);
    return (f3[0] == FUNCT3_BNE[0]) ? !zero : zero;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory port: store byte enables / replicated
// write data, load lane selection with sign or zero extension, and alignment check.
module lsu_align
  import PARAMS_pkg::*;
(
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [WD_SIZE-1:0]   st_data_i,
  input  logic [WD_SIZE-1:0]   ld_rdata_i,
  output logic [WD_SIZE/8-1:0] be_o,
  output logic [WD_SIZE-1:0]   wdata_o,
  output logic [WD_SIZE-1:0]   ld_data_o,
  output logic                 misalign_o
);

  acc_size_t  size;
  logic       ld_signed;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  // Lane selection, extension and enable generation for the decoded access size.
  always_comb begin
    size      = decode_size(funct3_i);
    ld_signed = !funct3_i[2];
    case (addr_lo_i)
      2'd1:    byte_sel = ld_rdata_i[15:8];
      2'd2:    byte_sel = ld_rdata_i[23:16];
      2'd3:    byte_sel = ld_rdata_i[31:24];
      default: byte_sel = ld_rdata_i[7:0];
    endcase
    half_sel   = addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    be_o       = 4'b1111;
    wdata_o    = st_data_i;
    ld_data_o  = ld_rdata_i;
    misalign_o = 1'b0;
    case (size)
      SZ_B: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{st_data_i[15:0]}};
        ld_data_o  = {{16{ld_signed & half_sel[15]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: registers ALU results, runs load/store transactions on a
// req/gnt/rvalid port, resolves branch/jump redirects and presents writeback data.
module stage_mem
  import PARAMS_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  input  logic [INSTR_REG_BITS-1:0] rd_i,
  input  logic                      instr_op_i,
  input  logic                      instr_ld_i,
  input  logic                      instr_st_i,
  input  logic                      instr_jm_i,
  input  logic                      instr_br_i,
  input  logic [2:0]                funct3_i,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic                      alu_zero_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic [INSTR_SIZE-1:0]     pc_target_i,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [INSTR_SIZE-1:0]     dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [WD_SIZE-1:0]        dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [WD_SIZE-1:0]        dmem_rdata_i,
  output logic                      valid_o,
  output logic [INSTR_REG_BITS-1:0] rd_o,
  output logic                      wb_en_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic                      redirect_o,
  output logic [INSTR_SIZE-1:0]     pc_target_o,
  output logic                      misalign_o
);

  mem_state_t                state_q, state_d;
  logic [INSTR_SIZE-1:0]     addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [WD_SIZE-1:0]        wdata_q, wdata_d;
  logic                      is_ld_q, is_ld_d;
  logic [2:0]                f3_q, f3_d;
  logic [1:0]                lo_q, lo_d;
  logic [INSTR_REG_BITS-1:0] mrd_q, mrd_d;

  logic                      valid_q, valid_d;
  logic [INSTR_REG_BITS-1:0] rd_q, rd_d;
  logic                      wb_cls_q, wb_cls_d;
  logic [WD_SIZE-1:0]        wb_data_q, wb_data_d;
  logic                      redirect_q, redirect_d;
  logic [INSTR_SIZE-1:0]     pc_target_q, pc_target_d;
  logic                      misalign_q, misalign_d;

  logic [2:0]         sel_f3;
  logic [1:0]         sel_lo;
  logic [3:0]         al_be;
  logic [WD_SIZE-1:0] al_wdata;
  logic [WD_SIZE-1:0] al_ld_data;
  logic               al_mis;
  logic               is_mem;

  // Aligner looks at live inputs while idle and at the captured access while a load waits.
  always_comb begin
    sel_f3 = (state_q == IDLE) ? funct3_i : f3_q;
    sel_lo = (state_q == IDLE) ? alu_result_i[1:0] : lo_q;
  end

  lsu_align u_lsu_align (
    .funct3_i   (sel_f3),
    .addr_lo_i  (sel_lo),
    .st_data_i  (rs2_data_i),
    .ld_rdata_i (dmem_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld_data),
    .misalign_o (al_mis)
  );

  // Transaction FSM: next state, captured access, memory port drive and writeback updates.
  always_comb begin
    is_mem      = instr_ld_i | instr_st_i;
    state_d     = state_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    is_ld_d     = is_ld_q;
    f3_d        = f3_q;
    lo_d        = lo_q;
    mrd_d       = mrd_q;
    valid_d     = 1'b0;
    rd_d        = rd_q;
    wb_cls_d    = wb_cls_q;
    wb_data_d   = wb_data_q;
    redirect_d  = redirect_q;
    pc_target_d = pc_target_q;
    misalign_d  = misalign_q;
    stall_o     = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    dmem_addr_o = '0;
    dmem_be_o   = '0;
    dmem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (is_mem && !al_mis) begin
            stall_o      = 1'b1;
            dmem_req_o   = 1'b1;
            dmem_we_o    = instr_st_i;
            dmem_addr_o  = {alu_result_i[INSTR_SIZE-1:2], 2'b00};
            dmem_be_o    = al_be;
            dmem_wdata_o = al_wdata;
            addr_d       = {alu_result_i[INSTR_SIZE-1:2], 2'b00};
            be_d         = al_be;
            wdata_d      = al_wdata;
            is_ld_d      = instr_ld_i;
            f3_d         = funct3_i;
            lo_d         = alu_result_i[1:0];
            mrd_d        = rd_i;
            if (!dmem_gnt_i) begin
              state_d = REQ;
            end else if (instr_ld_i) begin
              state_d = WAIT;
            end else begin
              valid_d    = 1'b1;
              rd_d       = rd_i;
              wb_cls_d   = 1'b0;
              redirect_d = 1'b0;
              misalign_d = 1'b0;
            end
          end else begin
            valid_d     = 1'b1;
            rd_d        = rd_i;
            wb_data_d   = alu_result_i;
            wb_cls_d    = instr_op_i | instr_ld_i | instr_jm_i;
            redirect_d  = !is_mem &
                          (instr_jm_i | (instr_br_i & branch_taken(alu_zero_i, funct3_i)));
            pc_target_d = pc_target_i;
            misalign_d  = is_mem;
          end
        end
      end
      REQ: begin
        stall_o      = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = !is_ld_q;
        dmem_addr_o  = addr_q;
        dmem_be_o    = be_q;
        dmem_wdata_o = wdata_q;
        if (dmem_gnt_i) begin
          if (is_ld_q) begin
            state_d = WAIT;
          end else begin
            state_d    = IDLE;
            valid_d    = 1'b1;
            rd_d       = mrd_q;
            wb_cls_d   = 1'b0;
            redirect_d = 1'b0;
            misalign_d = 1'b0;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_d    = IDLE;
          valid_d    = 1'b1;
          rd_d       = mrd_q;
          wb_cls_d   = 1'b1;
          wb_data_d  = al_ld_data;
          redirect_d = 1'b0;
          misalign_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured access and writeback registers; reset drops any open transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      is_ld_q     <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      mrd_q       <= '0;
      valid_q     <= 1'b0;
      rd_q        <= '0;
      wb_cls_q    <= 1'b0;
      wb_data_q   <= '0;
      redirect_q  <= 1'b0;
      pc_target_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      is_ld_q     <= is_ld_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      mrd_q       <= mrd_d;
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      wb_cls_q    <= wb_cls_d;
      wb_data_q   <= wb_data_d;
      redirect_q  <= redirect_d;
      pc_target_q <= pc_target_d;
      misalign_q  <= misalign_d;
    end
  end

  // Flag outputs only assert alongside the valid pulse.
  always_comb begin
    valid_o     = valid_q;
    rd_o        = rd_q;
    wb_data_o   = wb_data_q;
    pc_target_o = pc_target_q;
    redirect_o  = valid_q & redirect_q;
    misalign_o  = valid_q & misalign_q;
    wb_en_o     = valid_q & wb_cls_q & (rd_q != '0) & !misalign_q;
  end

endmodule
